usb_rx_byte_assembler: RTL and testbench
========================================

// Module: usb_rx_byte_assembler
// PURPOSE
//  Sits directly downstream of the NRZI decode stage in the USB receive path.
//  Consumes one decoded bit per shift_enable strobe.
//  Removes stuffed bits, assembles LSB-first bytes and flags stuffing and framing errors.
//  Presents each completed byte with a one-cycle valid pulse to the RX control unit / FIFO.
// PARAMETERS
//  DATA_W     8  width of an assembled data word
//  STUFF_RUN  6  consecutive 1s after which the next bit is a stuffed bit
// PORTS
//  clk           in   1       system clock
//  rst           in   1       synchronous, active-high reset
//  d_orig        in   1       decoded bit from decode stage
//  shift_enable  in   1       one-cycle strobe: d_orig valid this cycle
//  eop           in   1       end-of-packet seen (qualified by shift_enable)
//  rcving        in   1       packet in progress
//  rx_data       out  DATA_W  last completed byte, held until next byte
//  byte_valid    out  1       one-cycle pulse: rx_data updated
//  stuff_err     out  1       sticky: stuffed bit was 1
//  eop_err       out  1       sticky: EOP arrived with partial byte
//  crc_ok        out  1       CRC16 residual matched at EOP (see CONFIGURATION)
// BEHAVIOUR
//  - Reset (rst=1 at posedge): state IDLE, all counters 0; rx_data=0, byte_valid=0, stuff_err=0, eop_err=0, crc_ok=0.
//  - rst mid-packet discards any partial byte.
//  - FSM states: IDLE, SHIFT, STUFF, EOP_WAIT. rcving=0 in any state forces IDLE next cycle.
//  - IDLE->SHIFT when rcving=1. On entry:
//      clear bit_cnt, ones_cnt, stuff_err, eop_err, crc_ok.
//      seed CRC to 16'hFFFF.
//  - Normal data bit: SHIFT, shift_enable=1, eop=0.
//      shreg <= {d_orig, shreg[DATA_W-1:1]}; bit_cnt++ (wraps at DATA_W).
//      ones_cnt <= d_orig ? ones_cnt+1 : 0.
//  - Byte complete: bit_cnt wraps. rx_data <= assembled word; byte_valid=1 on the next cycle only.
//    Latency: 1 clk from the strobe carrying the last bit.
//  - Stuff detect: ones_cnt reaches STUFF_RUN -> STUFF.
//  - Stuffed bit: STUFF, shift_enable=1, eop=0.
//      Bit dropped (no shift, no bit_cnt or CRC update); ones_cnt <= 0.
//      d_orig=1 sets stuff_err. -> SHIFT.
//  - Byte wrap and stuff detect on the same bit: byte is emitted AND FSM enters STUFF.
//  - eop=1 with shift_enable=1 in SHIFT or STUFF: -> EOP_WAIT. Takes priority over shifting and stuffing.
//      bit_cnt!=0 sets eop_err; no byte_valid for the partial byte.
//      crc_ok latched.
//  - EOP_WAIT: strobes ignored; errors and crc_ok held until rcving=0 -> IDLE.
//  - shift_enable=0: no state, counter or output change except byte_valid returning to 0.
//  - stuff_err and eop_err stay set through EOP_WAIT and IDLE. Cleared only by rst or the next IDLE->SHIFT.
// CONFIGURATION
//  Macro USB_RX_CRC16_EN.
//  - Defined:
//      16-bit CRC (poly x^16+x^15+x^2+1) updated with every non-stuffed data bit in SHIFT.
//      At EOP, crc_ok = (crc == CRC16_RESIDUAL).
//  - Undefined: no CRC logic; crc_ok tied to 0. Port list unchanged.
// STRUCTURE
//  - Package usb_rx_pkg:
//      rx_state_t enum {IDLE, SHIFT, STUFF, EOP_WAIT}
//      STUFF_RUN_DEF=6
//      CRC16_POLY=16'h8005
//      CRC16_SEED=16'hFFFF
//      CRC16_RESIDUAL=16'h800D
//  - Sub-module usb_crc16: serial CRC with ports clk, rst, init, en, din, crc.
//    Instantiated only under USB_RX_CRC16_EN.
// TESTING
//  1. rcving=1; bits 1,0,1,1,0,1,0,0 with strobe every 8 clks
//     -> byte_valid 1 clk after 8th strobe, rx_data=8'h2D, errors 0.
//  2. Bytes 8'hFF,8'hFF with a 0 inserted after each run of six 1s
//     -> two byte_valid pulses, rx_data=8'hFF each, stuff_err=0.
//  3. Six 1s then stuffed bit 1 -> stuff_err=1, held until the next packet start.
//  4. eop strobe after 3 data bits -> eop_err=1, no byte_valid, FSM EOP_WAIT.
//     rcving=0 -> IDLE. Next packet start clears eop_err.
//  5. rst=1 for one clk after 5 bits of a byte
//     -> all outputs 0 next clk; next full byte 8'hA5 assembles correctly.
//  6. USB_RX_CRC16_EN: payload 8'h01 plus model-computed CRC16 bytes, then eop -> crc_ok=1.
//     Same stream with one payload bit flipped -> crc_ok=0.
//     Without the macro -> crc_ok=0 always.

Source files
------------

// File: rtl/usb_rx_pkg.sv
// Shared types and constants for the USB receive byte assembler.
// Holds the FSM state encoding plus the bit-stuffing and CRC16 parameters.
package usb_rx_pkg;

   typedef enum logic [1:0] {IDLE, SHIFT, STUFF, EOP_WAIT} rx_state_t;

   localparam int          STUFF_RUN_DEF  = 6;
   localparam logic [15:0] CRC16_POLY     = 16'h8005;
   localparam logic [15:0] CRC16_SEED     = 16'hFFFF;
   localparam logic [15:0] CRC16_RESIDUAL = 16'h800D;

endpackage

// File: rtl/usb_rx_crc16.sv
// Serial USB CRC16 (x^16+x^15+x^2+1), one bit per enabled cycle, MSB-side feedback.
// Only compiled when USB_RX_CRC16_EN is defined; the assembler builds without it otherwise.
`ifdef USB_RX_CRC16_EN
module usb_crc16
   import usb_rx_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        init,
   input  logic        en,
   input  logic        din,
   output logic [15:0] crc
);

   logic [15:0] crc_q;
   logic [15:0] crc_d;
   logic        fb;

   always_comb begin
      fb    = din ^ crc_q[15];
      crc_d = crc_q;
      if (init) begin
         crc_d = CRC16_SEED;
      end else if (en) begin
         crc_d = {crc_q[14:0], 1'b0} ^ (fb ? CRC16_POLY : 16'h0000);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         crc_q <= CRC16_SEED;
      end else begin
         crc_q <= crc_d;
      end
   end

   assign crc = crc_q;

endmodule
`endif

// File: rtl/usb_rx_byte_assembler.sv
// De-stuffs decoded USB bits, assembles LSB-first words and flags stuff/EOP errors.
// Optional CRC16 residual check at EOP when USB_RX_CRC16_EN is defined (crc_ok tied low otherwise).
module usb_rx_byte_assembler
   import usb_rx_pkg::*;
#(
   parameter int DATA_W    = 8,
   parameter int STUFF_RUN = STUFF_RUN_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              d_orig,
   input  logic              shift_enable,
   input  logic              eop,
   input  logic              rcving,
   output logic [DATA_W-1:0] rx_data,
   output logic              byte_valid,
   output logic              stuff_err,
   output logic              eop_err,
   output logic              crc_ok
);

   localparam int BC_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam int OC_W = $clog2(STUFF_RUN + 1);

   rx_state_t         state_q;
   logic [BC_W-1:0]   bit_cnt_q;
   logic [OC_W-1:0]   ones_cnt_q;
   logic [DATA_W-1:0] shreg_q;
   logic [DATA_W-1:0] rx_data_q;
   logic              byte_valid_q;
   logic              stuff_err_q;
   logic              eop_err_q;
   logic              crc_ok_q;

   logic [DATA_W-1:0] shreg_d;
   logic [OC_W-1:0]   ones_cnt_d;
   logic              byte_done;
   logic              crc_match;

   assign shreg_d    = {d_orig, shreg_q[DATA_W-1:1]};
   assign ones_cnt_d = d_orig ? ones_cnt_q + OC_W'(1) : '0;
   assign byte_done  = (bit_cnt_q == BC_W'(DATA_W - 1));

`ifdef USB_RX_CRC16_EN
   logic [15:0] crc;

   // CRC sees only real data bits: not the EOP strobe and never a stuffed bit.
   usb_crc16 u_crc16 (
      .clk  (clk),
      .rst  (rst),
      .init (state_q == IDLE && rcving),
      .en   (state_q == SHIFT && rcving && shift_enable && !eop),
      .din  (d_orig),
      .crc  (crc)
   );

   assign crc_match = (crc == CRC16_RESIDUAL);
`else
   assign crc_match = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         bit_cnt_q    <= '0;
         ones_cnt_q   <= '0;
         shreg_q      <= '0;
         rx_data_q    <= '0;
         byte_valid_q <= 1'b0;
         stuff_err_q  <= 1'b0;
         eop_err_q    <= 1'b0;
         crc_ok_q     <= 1'b0;
      end else begin
         byte_valid_q <= 1'b0;
         if (!rcving) begin
            state_q <= IDLE;
         end else begin
            case (state_q)
               IDLE: begin
                  state_q     <= SHIFT;
                  bit_cnt_q   <= '0;
                  ones_cnt_q  <= '0;
                  stuff_err_q <= 1'b0;
                  eop_err_q   <= 1'b0;
                  crc_ok_q    <= 1'b0;
               end
               SHIFT, STUFF: begin
                  if (shift_enable && eop) begin
                     state_q  <= EOP_WAIT;
                     crc_ok_q <= crc_match;
                     if (bit_cnt_q != '0) eop_err_q <= 1'b1;
                  end else if (shift_enable && state_q == STUFF) begin
                     ones_cnt_q <= '0;
                     state_q    <= SHIFT;
                     if (d_orig) stuff_err_q <= 1'b1;
                  end else if (shift_enable) begin
                     shreg_q    <= shreg_d;
                     ones_cnt_q <= ones_cnt_d;
                     bit_cnt_q  <= byte_done ? '0 : bit_cnt_q + BC_W'(1);
                     if (byte_done) begin
                        rx_data_q    <= shreg_d;
                        byte_valid_q <= 1'b1;
                     end
                     // A byte may complete on the same bit that finishes a run of ones.
                     if (ones_cnt_d == OC_W'(STUFF_RUN)) state_q <= STUFF;
                  end
               end
               EOP_WAIT: state_q <= EOP_WAIT;
               default:  state_q <= IDLE;
            endcase
         end
      end
   end

   assign rx_data    = rx_data_q;
   assign byte_valid = byte_valid_q;
   assign stuff_err  = stuff_err_q;
   assign eop_err    = eop_err_q;
   assign crc_ok     = crc_ok_q;

endmodule

// File: tb/tb_usb_rx_byte_assembler.sv
// Directed bench for usb_rx_byte_assembler: byte assembly, de-stuffing, errors, reset, CRC.
// CRC expectations follow USB_RX_CRC16_EN.
module tb_usb_rx_byte_assembler;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       d_orig = 1'b0;
   logic       shift_enable = 1'b0;
   logic       eop = 1'b0;
   logic       rcving = 1'b0;
   logic [7:0] rx_data;
   logic       byte_valid;
   logic       stuff_err;
   logic       eop_err;
   logic       crc_ok;

   int n_cmp = 0;
   int n_bad = 0;
   int bv_cnt = 0;
   int tx_ones = 0;
   logic [7:0] log_q[$];

   always #5 clk = ~clk;

   usb_rx_byte_assembler dut (
      .clk          (clk),
      .rst          (rst),
      .d_orig       (d_orig),
      .shift_enable (shift_enable),
      .eop          (eop),
      .rcving       (rcving),
      .rx_data      (rx_data),
      .byte_valid   (byte_valid),
      .stuff_err    (stuff_err),
      .eop_err      (eop_err),
      .crc_ok       (crc_ok)
   );

   always @(negedge clk) begin
      if (byte_valid === 1'b1) begin
         bv_cnt++;
         log_q.push_back(rx_data);
      end
   end

   task automatic strobe(input logic d, input logic e);
      @(negedge clk);
      d_orig = d;
      eop = e;
      shift_enable = 1'b1;
      @(negedge clk);
      shift_enable = 1'b0;
      eop = 1'b0;
      d_orig = 1'b0;
   endtask

   // Transmit-side stuffing: a 0 follows every run of six 1s.
   task automatic send_bit(input logic d);
      strobe(d, 1'b0);
      if (d) begin
         tx_ones++;
         if (tx_ones == 6) begin
            strobe(1'b0, 1'b0);
            tx_ones = 0;
         end
      end else begin
         tx_ones = 0;
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      for (int i = 0; i < 8; i++) send_bit(b[i]);
   endtask

   task automatic start_pkt();
      @(negedge clk);
      rcving = 1'b0;
      repeat (2) @(negedge clk);
      rcving = 1'b1;
      @(negedge clk);
      tx_ones = 0;
   endtask

   function automatic logic [15:0] crc_step(input logic [15:0] c, input logic d);
      logic fb;
      fb = d ^ c[15];
      crc_step = {c[14:0], 1'b0} ^ (fb ? 16'h8005 : 16'h0000);
   endfunction

   task automatic test_reset();
      rst = 1'b1;
      rcving = 1'b0;
      repeat (2) @(negedge clk);
      n_cmp++; if (rx_data !== 8'h00) begin n_bad++; $display("FAIL reset_rx_data got %h want 00", rx_data); end
      n_cmp++; if ({byte_valid, stuff_err, eop_err, crc_ok} !== 4'b0000) begin
         n_bad++; $display("FAIL reset_flags got %b want 0000", {byte_valid, stuff_err, eop_err, crc_ok});
      end
      rst = 1'b0;
   endtask

   task automatic test_basic_byte();
      logic [7:0] bits;
      int c0;
      bits = 8'b0010_1101;
      start_pkt();
      c0 = bv_cnt;
      for (int i = 0; i < 8; i++) begin
         strobe(bits[i], 1'b0);
         if (i == 6) begin
            n_cmp++; if (byte_valid !== 1'b0) begin n_bad++; $display("FAIL basic_early_valid got %b want 0", byte_valid); end
         end
         if (i == 7) begin
            n_cmp++; if (byte_valid !== 1'b1) begin n_bad++; $display("FAIL basic_valid got %b want 1", byte_valid); end
            n_cmp++; if (rx_data !== 8'h2D) begin n_bad++; $display("FAIL basic_data got %h want 2d", rx_data); end
            @(negedge clk);
            n_cmp++; if (byte_valid !== 1'b0) begin n_bad++; $display("FAIL basic_pulse_width got %b want 0", byte_valid); end
         end
         repeat (6) @(negedge clk);
      end
      n_cmp++; if (bv_cnt - c0 !== 1) begin n_bad++; $display("FAIL basic_count got %0d want 1", bv_cnt - c0); end
      n_cmp++; if ({stuff_err, eop_err} !== 2'b00) begin n_bad++; $display("FAIL basic_errs got %b want 00", {stuff_err, eop_err}); end
   endtask

   task automatic test_stuffed_ff();
      int c0;
      start_pkt();
      c0 = bv_cnt;
      log_q.delete();
      send_byte(8'hFF);
      send_byte(8'hFF);
      @(negedge clk);
      n_cmp++; if (bv_cnt - c0 !== 2) begin n_bad++; $display("FAIL ff_count got %0d want 2", bv_cnt - c0); end
      n_cmp++; if (log_q.size() != 2 || log_q[0] !== 8'hFF || log_q[1] !== 8'hFF) begin
         n_bad++; $display("FAIL ff_data got %p want two ff", log_q);
      end
      n_cmp++; if (stuff_err !== 1'b0) begin n_bad++; $display("FAIL ff_stuff_err got %b want 0", stuff_err); end
   endtask

   task automatic test_back_to_back();
      int c0;
      start_pkt();
      c0 = bv_cnt;
      log_q.delete();
      send_byte(8'hFC);
      send_byte(8'h03);
      @(negedge clk);
      n_cmp++; if (bv_cnt - c0 !== 2) begin n_bad++; $display("FAIL b2b_count got %0d want 2", bv_cnt - c0); end
      n_cmp++; if (log_q.size() != 2 || log_q[0] !== 8'hFC || log_q[1] !== 8'h03) begin
         n_bad++; $display("FAIL b2b_data got %p want fc 03", log_q);
      end
      n_cmp++; if (stuff_err !== 1'b0) begin n_bad++; $display("FAIL b2b_stuff_err got %b want 0", stuff_err); end
   endtask

   task automatic test_stuff_err();
      start_pkt();
      for (int i = 0; i < 6; i++) strobe(1'b1, 1'b0);
      n_cmp++; if (stuff_err !== 1'b0) begin n_bad++; $display("FAIL stuff_pre got %b want 0", stuff_err); end
      strobe(1'b1, 1'b0);
      n_cmp++; if (stuff_err !== 1'b1) begin n_bad++; $display("FAIL stuff_set got %b want 1", stuff_err); end
      strobe(1'b0, 1'b0);
      rcving = 1'b0;
      repeat (3) @(negedge clk);
      n_cmp++; if (stuff_err !== 1'b1) begin n_bad++; $display("FAIL stuff_hold_idle got %b want 1", stuff_err); end
      start_pkt();
      n_cmp++; if (stuff_err !== 1'b0) begin n_bad++; $display("FAIL stuff_clear got %b want 0", stuff_err); end
   endtask

   task automatic test_eop_err();
      int c0;
      start_pkt();
      c0 = bv_cnt;
      for (int i = 0; i < 3; i++) strobe(1'b0, 1'b0);
      strobe(1'b0, 1'b1);
      n_cmp++; if (eop_err !== 1'b1) begin n_bad++; $display("FAIL eop_set got %b want 1", eop_err); end
      for (int i = 0; i < 8; i++) strobe(1'b0, 1'b0);
      @(negedge clk);
      n_cmp++; if (bv_cnt - c0 !== 0) begin n_bad++; $display("FAIL eop_wait_ignores got %0d bytes want 0", bv_cnt - c0); end
      rcving = 1'b0;
      repeat (3) @(negedge clk);
      n_cmp++; if (eop_err !== 1'b1) begin n_bad++; $display("FAIL eop_hold got %b want 1", eop_err); end
      start_pkt();
      n_cmp++; if (eop_err !== 1'b0) begin n_bad++; $display("FAIL eop_clear got %b want 0", eop_err); end
   endtask

   task automatic test_mid_reset();
      logic [7:0] bits;
      start_pkt();
      strobe(1'b1, 1'b0); strobe(1'b1, 1'b0); strobe(1'b0, 1'b0);
      strobe(1'b1, 1'b0); strobe(1'b0, 1'b0);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      n_cmp++; if (rx_data !== 8'h00) begin n_bad++; $display("FAIL rst_rx_data got %h want 00", rx_data); end
      n_cmp++; if ({byte_valid, stuff_err, eop_err, crc_ok} !== 4'b0000) begin
         n_bad++; $display("FAIL rst_flags got %b want 0000", {byte_valid, stuff_err, eop_err, crc_ok});
      end
      @(negedge clk);
      bits = 8'hA5;
      for (int i = 0; i < 8; i++) strobe(bits[i], 1'b0);
      n_cmp++; if (byte_valid !== 1'b1 || rx_data !== 8'hA5) begin
         n_bad++; $display("FAIL rst_a5 got valid %b data %h want 1 a5", byte_valid, rx_data);
      end
   endtask

   task automatic test_crc();
      logic [15:0] c;
      logic        exp_ok;
      c = 16'hFFFF;
      for (int i = 0; i < 8; i++) c = crc_step(c, (i == 0));
      for (int pass = 0; pass < 2; pass++) begin
         start_pkt();
         send_byte(pass == 0 ? 8'h01 : 8'h00);
         for (int i = 15; i >= 0; i--) send_bit(~c[i]);
         strobe(1'b0, 1'b1);
`ifdef USB_RX_CRC16_EN
         exp_ok = (pass == 0);
`else
         exp_ok = 1'b0;
`endif
         n_cmp++; if (crc_ok !== exp_ok) begin n_bad++; $display("FAIL crc_ok_pass%0d got %b want %b", pass, crc_ok, exp_ok); end
         n_cmp++; if (eop_err !== 1'b0) begin n_bad++; $display("FAIL crc_eop_err_pass%0d got %b want 0", pass, eop_err); end
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

   initial begin
      test_reset();
      test_basic_byte();
      test_stuffed_ff();
      test_back_to_back();
      test_stuff_err();
      test_eop_err();
      test_mid_reset();
      test_crc();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
